// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
// Provides the serial-frame FSM state encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..B-1 per serial bit, ticks on the last cycle.
// Ports: uart_clock, rst (async, high), restart (hold count at 0), tick.
module uart_baud_tick #(
    parameter int B = 2
) (
    input  logic uart_clock,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (B > 1) ? $clog2(B) : 1;
    localparam logic [CW-1:0] LAST = CW'(B - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (restart || count_q == LAST) begin
            count_d = '0;
        end
    end

    assign tick = (count_q == LAST);

    always_ff @(posedge uart_clock or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: holding register feeding a shift register, START,
// N data bits MSB first, optional even parity, STOP; each bit B cycles.
// Ports: uart_clock, rst (async, high), tx_data/tx_valid/tx_ready
// (accept on valid && ready), serial_out (idles high), busy.
// Build macro UART_TX_PARITY_EN adds the PARITY bit to every frame.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int N = 8,
    parameter int B = 2
) (
    input  logic         uart_clock,
    input  logic         rst,
    input  logic [N-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic         serial_out,
    output logic         busy
);

    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam logic [NW-1:0] LAST_BIT = NW'(N - 1);

    uart_state_e   state_q, state_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [N-1:0]  hold_data_q, hold_data_d;
    logic          hold_full_q, hold_full_d;
    logic [NW-1:0] bit_cnt_q, bit_cnt_d;
    logic          serial_q, serial_d;
    logic          tx_ready_q, tx_ready_d;
    logic          busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic tick;
    logic restart;
    logic load;
    logic accept;

    // Counter is parked at 0 while idle so START always gets B full cycles.
    assign restart = (state_q == IDLE);
    assign accept  = tx_valid && tx_ready_q;

    uart_baud_tick #(
        .B(B)
    ) u_baud (
        .uart_clock(uart_clock),
        .rst       (rst),
        .restart   (restart),
        .tick      (tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        load        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d = START;
                    load    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q << 1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (tick) begin
                    state_d = STOP;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (tick) begin
                    if (hold_full_q) begin
                        state_d = START;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d     = hold_data_q;
            hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d    = ^hold_data_q;
`endif
        end

        // A new byte landing on the transfer edge keeps the register full.
        if (accept) begin
            hold_data_d = tx_data;
            hold_full_d = 1'b1;
        end

        serial_d = 1'b1;
        if (state_d == START) begin
            serial_d = 1'b0;
        end
        if (state_d == DATA) begin
            serial_d = shift_d[N-1];
        end
`ifdef UART_TX_PARITY_EN
        if (state_d == PARITY) begin
            serial_d = parity_d;
        end
`endif

        tx_ready_d = !hold_full_d;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge uart_clock or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            serial_q    <= 1'b1;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            serial_q    <= serial_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign tx_ready   = tx_ready_q;
    assign serial_out = serial_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter (N=8, B=2).
// Line samples are checked frame by frame against a queued expectation.
module tb_uart_transmitter;

    localparam int N = 8;
    localparam int B = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FB = N + 3;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FB = N + 2;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FS = FB * B;

    logic         uart_clock;
    logic         rst;
    logic [N-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         serial_out;
    logic         busy;

    uart_transmitter #(
        .N(N),
        .B(B)
    ) dut (
        .uart_clock(uart_clock),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .serial_out(serial_out),
        .busy      (busy)
    );

    initial uart_clock = 1'b0;
    always #5 uart_clock = ~uart_clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb[$];

    bit          in_frame = 1'b0;
    int          cyc = 0;
    logic [31:0] got = '0;
    int          gap = 0;
    int          last_gap = -1;
    int          bcnt = 0;
    int          last_busy = 0;
    int          frames = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Expected per-cycle line samples: sample j lives in bit j.
    function automatic logic [31:0] exp_frame(input logic [7:0] d,
                                              input logic par);
        logic [31:0] v;
        logic        bits[16];
        int          nb;
        v = '0;
        nb = 0;
        bits[nb++] = 1'b0;
        for (int i = N - 1; i >= 0; i--) bits[nb++] = d[i];
        if (PAR_EN) bits[nb++] = par;
        bits[nb++] = 1'b1;
        for (int i = 0; i < nb; i++)
            for (int k = 0; k < B; k++)
                v[i*B+k] = bits[i];
        return v;
    endfunction

    // Line monitor: starts a frame on the first low sample.
    always @(negedge uart_clock) begin
        if (rst) begin
            in_frame = 1'b0;
            cyc  = 0;
            bcnt = 0;
            gap  = 0;
        end else begin
            if (busy) bcnt++;
            else if (bcnt != 0) begin
                last_busy = bcnt;
                bcnt = 0;
            end
            if (!in_frame) begin
                if (serial_out === 1'b0) begin
                    in_frame = 1'b1;
                    got = '0;
                    cyc = 1;
                    last_gap = gap;
                    gap = 0;
                end else begin
                    gap++;
                end
            end else begin
                got[cyc] = serial_out;
                cyc++;
                if (cyc == FS) begin
                    in_frame = 1'b0;
                    frames++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %h expected none",
                                 got);
                    end else begin
                        check("frame", got, sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic par);
        int w;
        w = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && w < 500) begin
            @(posedge uart_clock);
            #1;
            w++;
        end
        if (!tx_ready) begin
            bound_fail("send_timeout");
        end else begin
            @(posedge uart_clock);
            sb.push_back(exp_frame(d, par));
            #1;
        end
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((sb.size() != 0 || busy || in_frame) && w < 1000) begin
            @(posedge uart_clock);
            #1;
            w++;
        end
        if (w >= 1000) bound_fail("idle_timeout");
        @(negedge uart_clock);
        #1;
    endtask

    initial begin
        int lowcnt;
        int f0;

        tbl[0] = '{8'hA5, 1'b0};
        tbl[1] = '{8'h07, 1'b1};
        tbl[2] = '{8'h80, 1'b1};
        tbl[3] = '{8'h00, 1'b0};
        tbl[4] = '{8'hFF, 1'b0};
        tbl[5] = '{8'h6E, 1'b1};
        tbl[6] = '{8'h55, 1'b0};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) @(posedge uart_clock);
        #1;
        check("rst_serial", serial_out, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(posedge uart_clock);
        #1;
        check("idle_serial", serial_out, 1);

        // Accept-to-line-fall latency on 0xA5.
        send(8'hA5, 1'b0);
        check("acc_serial", serial_out, 1);
        check("acc_ready", tx_ready, 0);
        check("acc_busy", busy, 0);
        @(posedge uart_clock);
        #1;
        check("lat_serial", serial_out, 0);
        check("lat_ready", tx_ready, 1);
        check("lat_busy", busy, 1);
        wait_idle();
        check("busy_len_a5", last_busy, FS);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].data, tbl[i].par);
            wait_idle();
            check("busy_len", last_busy, FS);
        end

        // Back-to-back frames.
        f0 = frames;
        send(8'h01, 1'b1);
        check("b2b_ready_drop", tx_ready, 0);
        @(posedge uart_clock);
        #1;
        check("b2b_ready_back", tx_ready, 1);
        send(8'hFF, 1'b0);
        lowcnt = 0;
        while (!tx_ready && lowcnt < 200) begin
            lowcnt++;
            @(posedge uart_clock);
            #1;
        end
        check("b2b_ready_low", lowcnt, FS - 1);
        check("b2b_start2", serial_out, 0);
        wait_idle();
        check("b2b_gap", last_gap, 0);
        check("b2b_frames", frames - f0, 2);
        check("b2b_busy_len", last_busy, 2 * FS);

        // Reset during DATA bit 3 of 0x3C.
        f0 = frames;
        send(8'h3C, 1'b0);
        repeat (9) @(posedge uart_clock);
        #1;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_serial", serial_out, 1);
        check("mid_rst_ready", tx_ready, 1);
        check("mid_rst_busy", busy, 0);
        sb.delete();
        repeat (2) @(posedge uart_clock);
        #1;
        rst = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge uart_clock);
            if (serial_out !== 1'b1 || busy !== 1'b0) lowcnt++;
        end
        check("post_rst_quiet", lowcnt, 0);
        check("post_rst_frames", frames - f0, 0);
        send(8'h55, 1'b0);
        wait_idle();
        check("post_rst_frame_cnt", frames - f0, 1);
        check("post_rst_busy_len", last_busy, FS);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
